// File: rtl/lobster_ptw_if.sv
// Miss, memory and TLB/fault channels of the two-level page-table walker.
// master = environment (MMU + memory), slave = walker.
interface lobster_ptw_if #(
  parameter int ADDR_WIDTH = 36,
  parameter int PTE_WIDTH  = 64
);
  logic                  miss_valid;
  logic                  miss_ready;
  logic [ADDR_WIDTH-1:0] miss_vaddr;
  logic                  miss_write;
  logic                  miss_exec;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [PTE_WIDTH-1:0]  mem_rsp_data;

  logic                  tlb_we;
  logic [23:0]           tlb_vpn;
  logic [PTE_WIDTH-1:0]  tlb_page;
  logic                  fault_valid;
  logic [1:0]            fault_cause;

  modport master (
    output miss_valid, miss_vaddr, miss_write, miss_exec,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  miss_ready, mem_req_valid, mem_req_addr,
           tlb_we, tlb_vpn, tlb_page, fault_valid, fault_cause
  );

  modport slave (
    input  miss_valid, miss_vaddr, miss_write, miss_exec,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output miss_ready, mem_req_valid, mem_req_addr,
           tlb_we, tlb_vpn, tlb_page, fault_valid, fault_cause
  );
endinterface

// File: rtl/lobster_ptw.sv
// Two-level page-table walker: 36-bit VA, 4 KiB pages, 4096-entry tables.
// One walk in flight; flush drains any outstanding memory read before going idle.
module lobster_ptw #(
  parameter int ADDR_WIDTH = 36,
  parameter int PTE_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ptbr,
  input  logic                  flush,
  output logic [31:0]           walk_count,
  lobster_ptw_if.slave          bus
);

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, FILL, FAULT, DRAIN
  } state_e;

  state_e      state;
  logic [23:0] vpn_q;
  logic        write_q;
  logic        exec_q;
  logic [20:0] l1_base_q;

  logic pte_v, pte_w, pte_x;
  assign pte_v = bus.mem_rsp_data[0];
  assign pte_w = bus.mem_rsp_data[2];
  assign pte_x = bus.mem_rsp_data[3];

  assign bus.tlb_vpn = vpn_q;

  // ptbr is only looked at while the L1 request is being presented
  always_comb begin
    bus.mem_req_addr = '0;
    case (state)
      L1_REQ:  bus.mem_req_addr = {ptbr[35:15], vpn_q[23:12], 3'b000};
      L2_REQ:  bus.mem_req_addr = {l1_base_q, vpn_q[11:0], 3'b000};
      default: bus.mem_req_addr = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{ptbr[14:0], bus.miss_vaddr[11:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      vpn_q             <= '0;
      write_q           <= 1'b0;
      exec_q            <= 1'b0;
      l1_base_q         <= '0;
      bus.miss_ready    <= 1'b1;
      bus.mem_req_valid <= 1'b0;
      bus.tlb_we        <= 1'b0;
      bus.tlb_page      <= '0;
      bus.fault_valid   <= 1'b0;
      bus.fault_cause   <= 2'd0;
      walk_count        <= '0;
    end else begin
      case (state)
        IDLE: if (bus.miss_valid) begin
          vpn_q             <= bus.miss_vaddr[35:12];
          write_q           <= bus.miss_write;
          exec_q            <= bus.miss_exec;
          bus.miss_ready    <= 1'b0;
          bus.mem_req_valid <= 1'b1;
          state             <= L1_REQ;
        end
        L1_REQ, L2_REQ: begin
          if (flush) begin
            // once the request is accepted a response is owed and must be drained
            bus.mem_req_valid <= 1'b0;
            bus.miss_ready    <= !bus.mem_req_ready;
            state             <= bus.mem_req_ready ? DRAIN : IDLE;
          end else if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= (state == L1_REQ) ? L1_WAIT : L2_WAIT;
          end
        end
        L1_WAIT: begin
          if (flush) begin
            bus.miss_ready <= bus.mem_rsp_valid;
            state          <= bus.mem_rsp_valid ? IDLE : DRAIN;
          end else if (bus.mem_rsp_valid) begin
            if (!pte_v) begin
              bus.fault_valid <= 1'b1;
              bus.fault_cause <= 2'd0;
              state           <= FAULT;
            end else begin
              l1_base_q         <= bus.mem_rsp_data[35:15];
              bus.mem_req_valid <= 1'b1;
              state             <= L2_REQ;
            end
          end
        end
        L2_WAIT: begin
          if (flush) begin
            bus.miss_ready <= bus.mem_rsp_valid;
            state          <= bus.mem_rsp_valid ? IDLE : DRAIN;
          end else if (bus.mem_rsp_valid) begin
            if (!pte_v) begin
              bus.fault_valid <= 1'b1;
              bus.fault_cause <= 2'd1;
              state           <= FAULT;
            end else if ((write_q && !pte_w) || (exec_q && !pte_x)) begin
              bus.fault_valid <= 1'b1;
              bus.fault_cause <= 2'd2;
              state           <= FAULT;
            end else begin
              bus.tlb_we   <= 1'b1;
              bus.tlb_page <= bus.mem_rsp_data;
              state        <= FILL;
            end
          end
        end
        FILL: begin
          bus.tlb_we     <= 1'b0;
          bus.miss_ready <= 1'b1;
          walk_count     <= walk_count + 32'd1;
          state          <= IDLE;
        end
        FAULT: begin
          bus.fault_valid <= 1'b0;
          bus.miss_ready  <= 1'b1;
          walk_count      <= walk_count + 32'd1;
          state           <= IDLE;
        end
        DRAIN: if (bus.mem_rsp_valid) begin
          bus.miss_ready <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          bus.miss_ready <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
